// File: rtl/regfile_pkg.sv
// Shared defaults and types for the scoreboarded register file.
// Imported by regfile_sb and its per-port read logic.
package regfile_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int NREGS_DEF  = 32;
    localparam int ADDR_W_DEF = $clog2(NREGS_DEF);

    typedef logic [ADDR_W_DEF-1:0] addr_t;

endpackage

// File: rtl/rf_read_port.sv
// One read port: write-winner bypass, busy look-ahead, capture regs.
// Captured values reflect the register/scoreboard state after the edge.
module rf_read_port
    import regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int NREGS  = NREGS_DEF,
    parameter int NWR    = 2,
    parameter int ADDR_W = $clog2(NREGS)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic [ADDR_W-1:0]            addr,
    input  logic [NREGS-1:0][DATA_W-1:0] regs,
    input  logic [NREGS-1:0]             busy,
    input  logic [NWR-1:0]               wr_en,
    input  logic [NWR*ADDR_W-1:0]        wr_addr,
    input  logic [NWR*DATA_W-1:0]        wr_data,
    input  logic                         iss_en,
    input  logic [ADDR_W-1:0]            iss_addr,
    output logic [DATA_W-1:0]            rd_data,
    output logic                         rd_busy
);

    logic              valid;
    logic [DATA_W-1:0] data_nxt;
    logic              busy_nxt;

    // Post-edge view of the addressed register; later write ports win.
    always_comb begin
        valid    = 1'b0;
        data_nxt = '0;
        busy_nxt = 1'b0;
        for (int i = 0; i < NREGS; i++) begin
            if (addr == ADDR_W'(i)) begin
                valid    = (i != 0);
                data_nxt = (i != 0) ? regs[i] : '0;
                busy_nxt = (i != 0) ? busy[i] : 1'b0;
            end
        end
        for (int w = 0; w < NWR; w++) begin
            if (valid && wr_en[w] &&
                wr_addr[w*ADDR_W +: ADDR_W] == addr) begin
                data_nxt = wr_data[w*DATA_W +: DATA_W];
                busy_nxt = 1'b0;
            end
        end
        if (valid && iss_en && iss_addr == addr) begin
            busy_nxt = 1'b1;
        end
    end

    // Capture on enabled reads, otherwise hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= '0;
            rd_busy <= 1'b0;
        end else if (en) begin
            rd_data <= data_nxt;
            rd_busy <= busy_nxt;
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// Multi-port register file with an in-order issue scoreboard.
// Register 0 is hardwired to zero and never busy.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter  int DATA_W = DATA_W_DEF,
    parameter  int NREGS  = NREGS_DEF,
    parameter  int NRD    = 2,
    parameter  int NWR    = 2,
    localparam int ADDR_W = $clog2(NREGS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NRD-1:0]         rd_en,
    input  logic [NRD*ADDR_W-1:0]  rd_addr,
    output logic [NRD*DATA_W-1:0]  rd_data,
    output logic [NRD-1:0]         rd_busy,
    input  logic [NWR-1:0]         wr_en,
    input  logic [NWR*ADDR_W-1:0]  wr_addr,
    input  logic [NWR*DATA_W-1:0]  wr_data,
    input  logic                   iss_en,
    input  logic [ADDR_W-1:0]      iss_addr,
    output logic [NREGS-1:0]       busy_vec,
    output logic                   wr_zero_err
);

    logic [NREGS-1:0][DATA_W-1:0] regs;
    logic [NREGS-1:0]             busy;
    logic [NREGS-1:0]             busy_nxt;
    logic                         zero_hit;

    // Storage update; later ports overwrite earlier ones on collision.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs <= '0;
        end else begin
            for (int i = 1; i < NREGS; i++) begin
                for (int w = 0; w < NWR; w++) begin
                    if (wr_en[w] &&
                        wr_addr[w*ADDR_W +: ADDR_W] == ADDR_W'(i)) begin
                        regs[i] <= wr_data[w*DATA_W +: DATA_W];
                    end
                end
            end
        end
    end

    // Next scoreboard: writes clear, a same-cycle issue re-sets.
    always_comb begin
        busy_nxt    = busy;
        busy_nxt[0] = 1'b0;
        for (int i = 1; i < NREGS; i++) begin
            for (int w = 0; w < NWR; w++) begin
                if (wr_en[w] &&
                    wr_addr[w*ADDR_W +: ADDR_W] == ADDR_W'(i)) begin
                    busy_nxt[i] = 1'b0;
                end
            end
            if (iss_en && iss_addr == ADDR_W'(i)) begin
                busy_nxt[i] = 1'b1;
            end
        end
    end

    // Flag any enabled write aimed at register 0.
    always_comb begin
        zero_hit = 1'b0;
        for (int w = 0; w < NWR; w++) begin
            if (wr_en[w] && wr_addr[w*ADDR_W +: ADDR_W] == '0) begin
                zero_hit = 1'b1;
            end
        end
    end

    // Scoreboard and error pulse registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy        <= '0;
            wr_zero_err <= 1'b0;
        end else begin
            busy        <= busy_nxt;
            wr_zero_err <= zero_hit;
        end
    end

    assign busy_vec = busy;

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        rf_read_port #(
            .DATA_W (DATA_W),
            .NREGS  (NREGS),
            .NWR    (NWR),
            .ADDR_W (ADDR_W)
        ) u_rd (
            .clk      (clk),
            .rst      (rst),
            .en       (rd_en[p]),
            .addr     (rd_addr[p*ADDR_W +: ADDR_W]),
            .regs     (regs),
            .busy     (busy),
            .wr_en    (wr_en),
            .wr_addr  (wr_addr),
            .wr_data  (wr_data),
            .iss_en   (iss_en),
            .iss_addr (iss_addr),
            .rd_data  (rd_data[p*DATA_W +: DATA_W]),
            .rd_busy  (rd_busy[p])
        );
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: directed table, randomized model compare,
// and asynchronous reset checks.
module tb_regfile_sb;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  rd_en = '0;
    logic [9:0]  rd_addr = '0;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic [1:0]  wr_en = '0;
    logic [9:0]  wr_addr = '0;
    logic [63:0] wr_data = '0;
    logic        iss_en = 1'b0;
    logic [4:0]  iss_addr = '0;
    logic [31:0] busy_vec;
    logic        wr_zero_err;

    int total = 0;
    int bad   = 0;

    regfile_sb dut (
        .clk         (clk),
        .rst         (rst),
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .rd_busy     (rd_busy),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .iss_en      (iss_en),
        .iss_addr    (iss_addr),
        .busy_vec    (busy_vec),
        .wr_zero_err (wr_zero_err)
    );

    always #5 clk = ~clk;

    // Reference state: architectural registers and producer-pending bits.
    logic [31:0] m_regs [32];
    logic        m_busy [32];
    logic [31:0] m_rd [2];
    logic        m_rb [2];
    logic        m_zerr;

    typedef struct {
        logic [1:0]  ren;
        logic [4:0]  ra0, ra1;
        logic [1:0]  we;
        logic [4:0]  wa0, wa1;
        logic [31:0] wd0, wd1;
        logic        ie;
        logic [4:0]  ia;
        logic [31:0] e_rd0, e_rd1;
        logic [1:0]  e_rb;
        logic [31:0] e_bv;
        logic        e_z;
    } vec_t;

    vec_t tv [11];

    function automatic vec_t mk(
        input logic [1:0] ren, input logic [4:0] ra0, ra1,
        input logic [1:0] we, input logic [4:0] wa0, wa1,
        input logic [31:0] wd0, wd1, input logic ie,
        input logic [4:0] ia, input logic [31:0] e_rd0, e_rd1,
        input logic [1:0] e_rb, input logic [31:0] e_bv,
        input logic e_z);
        vec_t v;
        v.ren = ren; v.ra0 = ra0; v.ra1 = ra1;
        v.we = we; v.wa0 = wa0; v.wa1 = wa1;
        v.wd0 = wd0; v.wd1 = wd1; v.ie = ie; v.ia = ia;
        v.e_rd0 = e_rd0; v.e_rd1 = e_rd1; v.e_rb = e_rb;
        v.e_bv = e_bv; v.e_z = e_z;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 1'b0;
        end
        m_rd[0] = '0; m_rd[1] = '0;
        m_rb[0] = 1'b0; m_rb[1] = 1'b0;
        m_zerr = 1'b0;
    endtask

    // Apply the rules in order: writes (later port wins), then issue;
    // reads observe the resulting state.
    task automatic model_step();
        logic [4:0] a;
        m_zerr = 1'b0;
        for (int w = 0; w < 2; w++) begin
            a = wr_addr[w*5 +: 5];
            if (wr_en[w]) begin
                if (a == 0) m_zerr = 1'b1;
                else begin
                    m_regs[a] = wr_data[w*32 +: 32];
                    m_busy[a] = 1'b0;
                end
            end
        end
        if (iss_en && iss_addr != 0) m_busy[iss_addr] = 1'b1;
        for (int p = 0; p < 2; p++) begin
            a = rd_addr[p*5 +: 5];
            if (rd_en[p]) begin
                m_rd[p] = (a == 0) ? 32'h0 : m_regs[a];
                m_rb[p] = (a == 0) ? 1'b0 : m_busy[a];
            end
        end
    endtask

    function automatic logic [31:0] m_bv();
        logic [31:0] v;
        for (int i = 0; i < 32; i++) v[i] = m_busy[i];
        return v;
    endfunction

    task automatic cyc(input logic [1:0] ren, input logic [4:0] ra0, ra1,
                       input logic [1:0] we, input logic [4:0] wa0, wa1,
                       input logic [31:0] wd0, wd1, input logic ie,
                       input logic [4:0] ia);
        rd_en = ren; rd_addr = {ra1, ra0};
        wr_en = we; wr_addr = {wa1, wa0}; wr_data = {wd1, wd0};
        iss_en = ie; iss_addr = ia;
        @(posedge clk);
        model_step();
        @(negedge clk);
        rd_en = '0; wr_en = '0; iss_en = 1'b0;
    endtask

    function automatic logic [4:0] raddr();
        if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
        return 5'($urandom_range(0, 7));
    endfunction

    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();

        tv[0]  = mk(2'b11, 5, 0, 2'b01, 5, 0, 32'hDEADBEEF, 0, 0, 0,
                    32'hDEADBEEF, 0, 2'b00, 0, 0);
        tv[1]  = mk(2'b11, 5, 7, 2'b11, 7, 7, 32'h11, 32'h22, 0, 0,
                    32'hDEADBEEF, 32'h22, 2'b00, 0, 0);
        tv[2]  = mk(2'b11, 7, 7, 2'b00, 0, 0, 0, 0, 0, 0,
                    32'h22, 32'h22, 2'b00, 0, 0);
        tv[3]  = mk(2'b11, 0, 7, 2'b01, 0, 0, 32'hFFFF, 0, 0, 0,
                    0, 32'h22, 2'b00, 0, 1);
        tv[4]  = mk(2'b01, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0,
                    0, 32'h22, 2'b00, 0, 0);
        tv[5]  = mk(2'b01, 9, 0, 2'b00, 0, 0, 0, 0, 1, 9,
                    0, 32'h22, 2'b01, 32'h200, 0);
        tv[6]  = mk(2'b10, 0, 9, 2'b00, 0, 0, 0, 0, 0, 0,
                    0, 0, 2'b11, 32'h200, 0);
        tv[7]  = mk(2'b00, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0,
                    0, 0, 2'b11, 32'h200, 0);
        tv[8]  = mk(2'b01, 9, 0, 2'b10, 0, 9, 0, 32'h99, 1, 9,
                    32'h99, 0, 2'b11, 32'h200, 0);
        tv[9]  = mk(2'b11, 9, 9, 2'b01, 9, 0, 32'hAA, 0, 0, 0,
                    32'hAA, 32'hAA, 2'b00, 0, 0);
        tv[10] = mk(2'b01, 0, 0, 2'b00, 0, 0, 0, 0, 1, 0,
                    0, 32'hAA, 2'b00, 0, 0);

        // Outputs held at zero while reset is asserted.
        #3;
        chk("rst_rd_data", rd_data[31:0] | rd_data[63:32], 0);
        chk("rst_busy", {29'b0, wr_zero_err, rd_busy}, 0);
        chk("rst_bv", busy_vec, 0);
        @(negedge clk);
        rst = 1'b0;

        // Every register reads zero and idle after reset.
        for (int a = 0; a < 32; a++) begin
            cyc(2'b11, 5'(a), 5'(a), 0, 0, 0, 0, 0, 0, 0);
            chk($sformatf("init r%0d d", a), rd_data[31:0] | rd_data[63:32], 0);
            chk($sformatf("init r%0d b", a), {30'b0, rd_busy}, 0);
        end

        // Directed sequence covering bypass, collision, r0, scoreboard.
        for (int i = 0; i < 11; i++) begin
            cyc(tv[i].ren, tv[i].ra0, tv[i].ra1, tv[i].we, tv[i].wa0,
                tv[i].wa1, tv[i].wd0, tv[i].wd1, tv[i].ie, tv[i].ia);
            chk($sformatf("v%0d rd0", i), rd_data[31:0], tv[i].e_rd0);
            chk($sformatf("v%0d rd1", i), rd_data[63:32], tv[i].e_rd1);
            chk($sformatf("v%0d rb", i), {30'b0, rd_busy}, {30'b0, tv[i].e_rb});
            chk($sformatf("v%0d bv", i), busy_vec, tv[i].e_bv);
            chk($sformatf("v%0d zerr", i), {31'b0, wr_zero_err}, {31'b0, tv[i].e_z});
        end

        // Randomized traffic against the reference model.
        for (int n = 0; n < 400; n++) begin
            cyc(2'($urandom_range(0, 3)), raddr(), raddr(),
                2'($urandom_range(0, 3)), raddr(), raddr(),
                $urandom, $urandom, 1'($urandom_range(0, 1)), raddr());
            chk($sformatf("rnd%0d rd0", n), rd_data[31:0], m_rd[0]);
            chk($sformatf("rnd%0d rd1", n), rd_data[63:32], m_rd[1]);
            chk($sformatf("rnd%0d rb", n), {30'b0, rd_busy},
                {30'b0, m_rb[1], m_rb[0]});
            chk($sformatf("rnd%0d bv", n), busy_vec, m_bv());
            chk($sformatf("rnd%0d z", n), {31'b0, wr_zero_err}, {31'b0, m_zerr});
        end

        // Set up nonzero state, then assert reset between edges.
        cyc(2'b11, 3, 4, 2'b11, 3, 0, 32'h1234, 32'h5, 1, 4);
        chk("pre_rst d0", rd_data[31:0], 32'h1234);
        chk("pre_rst rb1", {31'b0, rd_busy[1]}, 1);
        chk("pre_rst z", {31'b0, wr_zero_err}, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst d", rd_data[31:0] | rd_data[63:32], 0);
        chk("async_rst b", {29'b0, wr_zero_err, rd_busy}, 0);
        chk("async_rst bv", busy_vec, 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        cyc(2'b01, 3, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("post_rst r3", rd_data[31:0], 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
